// File: rtl/bitonic_sorter_pipe.sv
// Fully pipelined bitonic sorter: N = 2**LOG2N unsigned keys per vector, one compare-swap column per register stage.
// Optional macro SORTER_INDEX_EN adds per-key source-lane tags (stable sort) and the out_index port.
module bitonic_sorter_pipe #(
    parameter int WIDTH = 8,
    parameter int LOG2N = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_desc,
    input  logic [(WIDTH<<LOG2N)-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [(WIDTH<<LOG2N)-1:0]     out_data
`ifdef SORTER_INDEX_EN
    ,
    output logic [(LOG2N<<LOG2N)-1:0]     out_index
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int S  = LOG2N * (LOG2N + 1) / 2;
    localparam int KW = N * WIDTH;

    logic [KW-1:0] key_reg  [S];
    logic [KW-1:0] key_in   [S];
    logic [KW-1:0] key_next [S];
    logic [S-1:0]  valid_reg;
    logic [S-1:0]  valid_in;
    logic [S-1:0]  desc_in;
    logic          advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_reg[S-1];
    assign out_data  = key_reg[S-1];

    assign desc_in[0]  = in_desc;
    assign valid_in[0] = in_valid;
    assign key_in[0]   = in_data;

    for (genvar gi = 1; gi < S; gi++) begin : g_link
        assign key_in[gi]   = key_reg[gi-1];
        assign valid_in[gi] = valid_reg[gi-1];
    end

    // The last stage's direction bit feeds no comparator, so only S-1 are stored.
    if (S > 1) begin : g_desc
        logic [S-2:0] desc_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                desc_reg <= '0;
            end else if (advance) begin
                desc_reg <= desc_in[S-2:0];
            end
        end
        assign desc_in[S-1:1] = desc_reg;
    end

`ifdef SORTER_INDEX_EN
    localparam int IW = N * LOG2N;
    logic [IW-1:0] idx_reg  [S];
    logic [IW-1:0] idx_in   [S];
    logic [IW-1:0] idx_next [S];

    assign out_index = idx_reg[S-1];
    for (genvar gi = 0; gi < N; gi++) begin : g_tag
        assign idx_in[0][gi*LOG2N +: LOG2N] = LOG2N'(gi);
    end
    for (genvar gi = 1; gi < S; gi++) begin : g_tag_link
        assign idx_in[gi] = idx_reg[gi-1];
    end
`endif

    // Stage (p,q) maps to column K; lower lane of each pair has bit q-1 clear.
    for (genvar gp = 1; gp <= LOG2N; gp++) begin : g_phase
        for (genvar gq = gp; gq >= 1; gq--) begin : g_step
            localparam int K = gp * (gp - 1) / 2 + (gp - gq);
            localparam int D = 1 << (gq - 1);
            for (genvar gi = 0; gi < N; gi++) begin : g_lane
                if ((gi & D) == 0) begin : g_pair
                    localparam int J        = gi + D;
                    localparam bit BLK_DESC = ((gi >> gp) & 1) == 1;
                    logic [WIDTH-1:0] a;
                    logic [WIDTH-1:0] b;
                    logic             dir;
                    logic             swap;
                    assign a   = key_in[K][gi*WIDTH +: WIDTH];
                    assign b   = key_in[K][J*WIDTH +: WIDTH];
                    assign dir = BLK_DESC ^ desc_in[K];
`ifdef SORTER_INDEX_EN
                    logic [LOG2N-1:0]       ia;
                    logic [LOG2N-1:0]       ib;
                    logic [WIDTH+LOG2N-1:0] ca;
                    logic [WIDTH+LOG2N-1:0] cb;
                    assign ia = idx_in[K][gi*LOG2N +: LOG2N];
                    assign ib = idx_in[K][J*LOG2N +: LOG2N];
                    // Inverting tags for descending vectors keeps equal keys in input order.
                    assign ca = {a, ia ^ {LOG2N{desc_in[K]}}};
                    assign cb = {b, ib ^ {LOG2N{desc_in[K]}}};
                    assign idx_next[K][gi*LOG2N +: LOG2N] = swap ? ib : ia;
                    assign idx_next[K][J*LOG2N +: LOG2N]  = swap ? ia : ib;
`else
                    logic [WIDTH-1:0] ca;
                    logic [WIDTH-1:0] cb;
                    assign ca = a;
                    assign cb = b;
`endif
                    assign swap = dir ? (ca < cb) : (ca > cb);
                    assign key_next[K][gi*WIDTH +: WIDTH] = swap ? b : a;
                    assign key_next[K][J*WIDTH +: WIDTH]  = swap ? a : b;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            for (int k = 0; k < S; k++) begin
                key_reg[k] <= '0;
`ifdef SORTER_INDEX_EN
                idx_reg[k] <= '0;
`endif
            end
        end else if (advance) begin
            valid_reg <= valid_in;
            for (int k = 0; k < S; k++) begin
                key_reg[k] <= key_next[k];
`ifdef SORTER_INDEX_EN
                idx_reg[k] <= idx_next[k];
`endif
            end
        end
    end

endmodule
